// File: rtl/nco_multi_if.sv
// rtl/nco_multi_if.sv - slot/phase bus between the pitch pipeline, the NCO bank and the wavetable lookup
interface nco_multi_if #(
  parameter int VOICES    = 8,
  parameter int V_OSC     = 4,
  parameter int V_WIDTH   = 3,
  parameter int O_WIDTH   = 2,
  parameter int INC_WIDTH = 24,
  parameter int OUT_WIDTH = 11
);
  logic                 slot_en;
  logic [INC_WIDTH-1:0] osc_pitch_val;
  logic [VOICES-1:0]    osc_accum_zero;
  logic [V_OSC-1:0]     sync_mode;
  logic [V_WIDTH-1:0]   slot_vx;
  logic [O_WIDTH-1:0]   slot_ox;
  logic [OUT_WIDTH-1:0] phase_acc;
  logic [V_WIDTH-1:0]   phase_vx;
  logic [O_WIDTH-1:0]   phase_ox;
  logic                 phase_valid;
  logic                 phase_wrap;
  logic                 phase_frame;

  modport master (
    output slot_en, osc_pitch_val, osc_accum_zero, sync_mode,
    input  slot_vx, slot_ox, phase_acc, phase_vx, phase_ox,
           phase_valid, phase_wrap, phase_frame
  );

  modport slave (
    input  slot_en, osc_pitch_val, osc_accum_zero, sync_mode,
    output slot_vx, slot_ox, phase_acc, phase_vx, phase_ox,
           phase_valid, phase_wrap, phase_frame
  );
endinterface

// File: rtl/nco_multi.sv
// rtl/nco_multi.sv - time-multiplexed phase accumulator bank, one voice/oscillator slot per enabled clock
module nco_multi #(
  parameter int VOICES    = 8,
  parameter int V_OSC     = 4,
  parameter int V_WIDTH   = 3,
  parameter int O_WIDTH   = 2,
  parameter int INC_WIDTH = 24,
  parameter int ACC_WIDTH = 25,
  parameter int OUT_WIDTH = 11
) (
  input  logic       sCLK_XVXENVS,
  input  logic       reset_reg_N,
  nco_multi_if.slave bus
);

  logic [ACC_WIDTH-1:0] r_acc  [VOICES][V_OSC];
  logic                 r_pend [VOICES][V_OSC];
  logic [VOICES-1:0]    r_wrap0;
  logic [V_WIDTH-1:0]   r_slot_vx;
  logic [O_WIDTH-1:0]   r_slot_ox;

  logic [OUT_WIDTH-1:0] r_phase_acc;
  logic [V_WIDTH-1:0]   r_phase_vx;
  logic [O_WIDTH-1:0]   r_phase_ox;
  logic                 r_phase_valid;
  logic                 r_phase_wrap;
  logic                 r_phase_frame;

  logic [ACC_WIDTH-1:0] w_acc_cur;
  logic [ACC_WIDTH:0]   w_sum;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic                 w_carry;
  logic                 w_pend_hit;
  logic                 w_sync_hit;
  logic                 w_last_ox;
  logic                 w_last_vx;
  logic                 w_first_slot;

  always_comb begin
    w_acc_cur    = r_acc[r_slot_vx][r_slot_ox];
    w_pend_hit   = r_pend[r_slot_vx][r_slot_ox];
    w_sync_hit   = (r_slot_ox != '0) && bus.sync_mode[r_slot_ox] && r_wrap0[r_slot_vx];
    w_sum        = {1'b0, w_acc_cur} + {{(ACC_WIDTH + 1 - INC_WIDTH){1'b0}}, bus.osc_pitch_val};
    w_acc_next   = w_sum[ACC_WIDTH-1:0];
    w_carry      = w_sum[ACC_WIDTH];
    // note-on reset outranks hard sync; both report no carry
    if (w_pend_hit || w_sync_hit) begin
      w_acc_next = '0;
      w_carry    = 1'b0;
    end
    w_last_ox    = (r_slot_ox == O_WIDTH'(V_OSC - 1));
    w_last_vx    = (r_slot_vx == V_WIDTH'(VOICES - 1));
    w_first_slot = (r_slot_vx == '0) && (r_slot_ox == '0);
  end

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_slot_vx <= '0;
      r_slot_ox <= '0;
    end else if (bus.slot_en) begin
      if (w_last_ox) begin
        r_slot_ox <= '0;
        r_slot_vx <= w_last_vx ? '0 : r_slot_vx + 1'b1;
      end else begin
        r_slot_ox <= r_slot_ox + 1'b1;
      end
    end
  end

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      for (int v = 0; v < VOICES; v++) begin
        for (int o = 0; o < V_OSC; o++) begin
          r_acc[v][o] <= '0;
        end
      end
      r_wrap0 <= '0;
    end else if (bus.slot_en) begin
      r_acc[r_slot_vx][r_slot_ox] <= w_acc_next;
      if (r_slot_ox == '0) begin
        r_wrap0[r_slot_vx] <= w_carry;
      end
    end
  end

  // a held note-on request keeps re-arming, so it beats the clear of the slot being served
  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      for (int v = 0; v < VOICES; v++) begin
        for (int o = 0; o < V_OSC; o++) begin
          r_pend[v][o] <= 1'b0;
        end
      end
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        for (int o = 0; o < V_OSC; o++) begin
          if (bus.osc_accum_zero[v]) begin
            r_pend[v][o] <= 1'b1;
          end else if (bus.slot_en && (r_slot_vx == V_WIDTH'(v)) && (r_slot_ox == O_WIDTH'(o))) begin
            r_pend[v][o] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_phase_acc   <= '0;
      r_phase_vx    <= '0;
      r_phase_ox    <= '0;
      r_phase_valid <= 1'b0;
      r_phase_wrap  <= 1'b0;
      r_phase_frame <= 1'b0;
    end else if (bus.slot_en) begin
      r_phase_acc   <= w_acc_next[ACC_WIDTH-1 -: OUT_WIDTH];
      r_phase_vx    <= r_slot_vx;
      r_phase_ox    <= r_slot_ox;
      r_phase_valid <= 1'b1;
      r_phase_wrap  <= w_carry;
      r_phase_frame <= w_first_slot;
    end else begin
      r_phase_valid <= 1'b0;
      r_phase_frame <= 1'b0;
    end
  end

  assign bus.slot_vx     = r_slot_vx;
  assign bus.slot_ox     = r_slot_ox;
  assign bus.phase_acc   = r_phase_acc;
  assign bus.phase_vx    = r_phase_vx;
  assign bus.phase_ox    = r_phase_ox;
  assign bus.phase_valid = r_phase_valid;
  assign bus.phase_wrap  = r_phase_wrap;
  assign bus.phase_frame = r_phase_frame;

endmodule

// File: tb/tb_nco_multi.sv
// tb/tb_nco_multi.sv - self-checking bench for nco_multi against a slot-level arithmetic model
module tb_nco_multi;
  localparam int  VOICES    = 8;
  localparam int  V_OSC     = 4;
  localparam int  V_WIDTH   = 3;
  localparam int  O_WIDTH   = 2;
  localparam int  INC_WIDTH = 24;
  localparam int  ACC_WIDTH = 25;
  localparam int  OUT_WIDTH = 11;
  localparam longint ACC_MOD = 64'd1 << ACC_WIDTH;
  localparam int  SLOTS     = VOICES * V_OSC;

  logic clk = 1'b0;
  logic reset_reg_N = 1'b1;
  always #5 clk = ~clk;

  nco_multi_if #(
    .VOICES(VOICES), .V_OSC(V_OSC), .V_WIDTH(V_WIDTH), .O_WIDTH(O_WIDTH),
    .INC_WIDTH(INC_WIDTH), .OUT_WIDTH(OUT_WIDTH)
  ) bus ();

  nco_multi #(
    .VOICES(VOICES), .V_OSC(V_OSC), .V_WIDTH(V_WIDTH), .O_WIDTH(O_WIDTH),
    .INC_WIDTH(INC_WIDTH), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .sCLK_XVXENVS(clk),
    .reset_reg_N (reset_reg_N),
    .bus         (bus)
  );

  int ncmp = 0;
  int nfail = 0;

  // reference model: one accumulator per slot, plain modular arithmetic
  longint macc [VOICES][V_OSC];
  bit     mpend[VOICES][V_OSC];
  bit     mwrap0[VOICES];
  int     mv, mo;
  longint e_acc;
  int     e_vx, e_ox;
  bit     e_valid, e_wrap, e_frame;

  logic [INC_WIDTH-1:0] inc_tbl[VOICES][V_OSC];
  logic [VOICES-1:0]    zero_drv;
  logic [V_OSC-1:0]     sync_drv;

  task automatic chk(input string tag, input longint obs, input longint exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".phase_acc"},   longint'(bus.phase_acc),   e_acc);
    chk({ph, ".phase_vx"},    longint'(bus.phase_vx),    e_vx);
    chk({ph, ".phase_ox"},    longint'(bus.phase_ox),    e_ox);
    chk({ph, ".phase_valid"}, longint'(bus.phase_valid), e_valid);
    chk({ph, ".phase_wrap"},  longint'(bus.phase_wrap),  e_wrap);
    chk({ph, ".phase_frame"}, longint'(bus.phase_frame), e_frame);
    chk({ph, ".slot_vx"},     longint'(bus.slot_vx),     mv);
    chk({ph, ".slot_ox"},     longint'(bus.slot_ox),     mo);
  endtask

  task automatic model_reset();
    for (int v = 0; v < VOICES; v++) begin
      mwrap0[v] = 0;
      for (int o = 0; o < V_OSC; o++) begin
        macc[v][o]  = 0;
        mpend[v][o] = 0;
      end
    end
    mv = 0; mo = 0;
    e_acc = 0; e_vx = 0; e_ox = 0; e_valid = 0; e_wrap = 0; e_frame = 0;
  endtask

  task automatic model_step(input bit en);
    longint s;
    bit     carry;
    int     v, o;
    if (en) begin
      v = mv; o = mo; carry = 0;
      if (mpend[v][o]) begin
        macc[v][o]  = 0;
        mpend[v][o] = 0;
      end else if (o != 0 && sync_drv[o] && mwrap0[v]) begin
        macc[v][o] = 0;
      end else begin
        s          = macc[v][o] + longint'(inc_tbl[v][o]);
        carry      = (s >= ACC_MOD);
        macc[v][o] = s % ACC_MOD;
      end
      if (o == 0) mwrap0[v] = carry;
      e_acc   = macc[v][o] >> (ACC_WIDTH - OUT_WIDTH);
      e_vx    = v;
      e_ox    = o;
      e_valid = 1;
      e_wrap  = carry;
      e_frame = (v == 0 && o == 0);
      mo = mo + 1;
      if (mo == V_OSC) begin
        mo = 0;
        mv = (mv + 1) % VOICES;
      end
    end else begin
      e_valid = 0;
      e_frame = 0;
    end
    // note-on requests re-arm after the serviced slot's clear, so a held request wins
    for (int vv = 0; vv < VOICES; vv++) begin
      if (zero_drv[vv]) begin
        for (int oo = 0; oo < V_OSC; oo++) mpend[vv][oo] = 1;
      end
    end
  endtask

  task automatic step(input bit en, input string ph);
    bus.slot_en        = en;
    bus.osc_pitch_val  = inc_tbl[mv][mo];
    bus.osc_accum_zero = zero_drv;
    bus.sync_mode      = sync_drv;
    @(posedge clk);
    model_step(en);
    #1;
    check_all(ph);
  endtask

  task automatic do_reset(input string ph);
    #2;
    reset_reg_N = 1'b0;
    model_reset();
    #1;
    check_all(ph);
    @(negedge clk);
    reset_reg_N = 1'b1;
  endtask

  task automatic set_all_inc(input logic [INC_WIDTH-1:0] val);
    for (int v = 0; v < VOICES; v++)
      for (int o = 0; o < V_OSC; o++) inc_tbl[v][o] = val;
  endtask

  initial begin
    zero_drv = '0;
    sync_drv = '0;
    set_all_inc(24'h001000);
    bus.slot_en = 1'b0;
    bus.osc_pitch_val = '0;
    bus.osc_accum_zero = '0;
    bus.sync_mode = '0;

    // reset, then reset again while sitting at slot {1,1}
    do_reset("rst0");
    for (int i = 0; i < 5; i++) step(1'b1, "pre_rst");
    chk("at_slot_vx", longint'(bus.slot_vx), 1);
    chk("at_slot_ox", longint'(bus.slot_ox), 1);
    do_reset("rst_mid");
    step(1'b1, "rst_first");
    chk("rst_first_frame", longint'(bus.phase_frame), 1);
    chk("rst_first_vx", longint'(bus.phase_vx), 0);

    // wrap of slot {0,0} at update 2048
    set_all_inc('0);
    inc_tbl[0][0] = 24'h004000;
    do_reset("rst_wrap");
    for (int f = 1; f <= 2049; f++) begin
      for (int s = 0; s < SLOTS; s++) begin
        step(1'b1, "wrap");
        if (s == 0 && f == 1)    chk("wrap_first", longint'(bus.phase_acc), 1);
        if (s == 0 && f == 2047) chk("wrap_2047", longint'(bus.phase_acc), 2047);
        if (s == 0 && f == 2048) begin
          chk("wrap_zero", longint'(bus.phase_acc), 0);
          chk("wrap_flag", longint'(bus.phase_wrap), 1);
        end
        if (s == 0 && f == 2049) chk("wrap_after", longint'(bus.phase_acc), 1);
      end
    end

    // one-cycle note-on reset of voice 3 while slot {4,0} is served
    set_all_inc(24'h010000);
    do_reset("rst_note");
    for (int i = 0; i < 48; i++) step(1'b1, "note_pre");
    zero_drv = 8'h08;
    step(1'b1, "note_pulse");
    zero_drv = '0;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, "note_post");
      if (i >= 27 && i <= 30) chk("note_v3_zero", longint'(bus.phase_acc), 0);
    end

    // hard sync of voice 0 osc1 to osc0 wrap every 32 frames
    set_all_inc(24'h0C0000);
    inc_tbl[0][0] = 24'h100000;
    sync_drv = 4'b0010;
    do_reset("rst_sync");
    for (int f = 1; f <= 40; f++) begin
      for (int s = 0; s < SLOTS; s++) begin
        step(1'b1, "sync");
        if (f == 32 && s == 0) chk("sync_osc0_wrap", longint'(bus.phase_wrap), 1);
        if (f == 32 && s == 1) chk("sync_osc1_zero", longint'(bus.phase_acc), 0);
        if (f == 32 && s == 2) chk("sync_osc2_free", longint'(bus.phase_acc), (32 * 64'h0C0000 % ACC_MOD) >> 14);
      end
    end
    sync_drv = '0;

    // slot_en gap mid-frame
    for (int i = 0; i < 13; i++) step(1'b1, "gap_pre");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, "gap");
      chk("gap_hold_ox", longint'(bus.slot_ox), 1);
    end
    step(1'b1, "gap_resume");
    chk("gap_resume_ox", longint'(bus.phase_ox), 1);

    // held note-on across slot {2,1}: set wins, next frame also restarts
    set_all_inc(24'h010000);
    do_reset("rst_setwin");
    for (int i = 0; i < 7; i++) step(1'b1, "setwin_pre");
    zero_drv = 8'h04;
    for (int i = 0; i < 3; i++) step(1'b1, "setwin_hold");
    chk("setwin_now", longint'(bus.phase_acc), 0);
    zero_drv = '0;
    for (int i = 0; i < SLOTS; i++) step(1'b1, "setwin_next");
    chk("setwin_next_ox", longint'(bus.phase_ox), 1);
    chk("setwin_next_zero", longint'(bus.phase_acc), 0);

    // randomized traffic
    for (int v = 0; v < VOICES; v++)
      for (int o = 0; o < V_OSC; o++)
        inc_tbl[v][o] = INC_WIDTH'($urandom) >> $urandom_range(0, 12);
    do_reset("rst_rand");
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) sync_drv = V_OSC'($urandom);
      zero_drv = ($urandom_range(0, 7) == 0) ? (VOICES'($urandom) & VOICES'($urandom)) : '0;
      step($urandom_range(0, 4) != 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
